pipeline_ctrl: RTL

Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Each cycle it decides which latches load, which take a bubble, and whether the PC advances.
- Inputs are hazard conditions, memory handshakes, control-flow redirects and the halt signal.
- A small FSM handles data-memory waits and the halt/cache-flush drain. Saturating performance counters track total and stalled cycles.

---
 rtl/cpu_types_pkg.sv | 5 +
 rtl/pipeline_if.sv | 46 ++++
 rtl/sat_counter.sv | 16 +
 rtl/pipeline_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide type definitions.
package cpu_types_pkg;
  localparam int unsigned REG_W = 5;
  typedef logic [REG_W-1:0] regbits_t;
endpackage

// File: rtl/pipeline_if.sv
// Pipeline sequencing types: controller states and per-cycle latch control bundle.
package pipeline_if;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DWAIT   = 2'd1,
    HALTING = 2'd2,
    HALTED  = 2'd3
  } pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } latch_ctl_t;

  localparam latch_ctl_t CTL_IDLE = '{default: 1'b0};

  // Hazard priority for a cycle with no outstanding data-memory miss:
  // redirect beats load-use, which beats jump, which beats a fetch miss.
  function automatic latch_ctl_t run_ctl(input logic ihit, input logic br_taken,
                                         input logic lu, input logic jump);
    latch_ctl_t c;
    c = '{pc_en: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1, en_ex_mem: 1'b1,
          en_mem_wb: 1'b1, flush_if_id: 1'b0, flush_id_ex: 1'b0};
    if (br_taken) begin
      c.flush_if_id = 1'b1;
      c.flush_id_ex = 1'b1;
    end else if (lu) begin
      c.pc_en       = 1'b0;
      c.en_if_id    = 1'b0;
      c.flush_id_ex = 1'b1;
    end else if (jump) begin
      c.flush_if_id = 1'b1;
    end else if (!ihit) begin
      c.pc_en       = 1'b0;
      c.flush_if_id = 1'b1;
    end
    return c;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge CLK) begin
    if (!nRST)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch sequencer: hazard resolution, data-memory wait and halt/flush drain.
module pipeline_ctrl
  import cpu_types_pkg::*;
  import pipeline_if::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_memRen,
  input  logic             mem_memWen,
  input  logic             mem_halt,
  input  logic             ex_memRen,
  input  regbits_t         ex_regDest,
  input  regbits_t         dec_rs,
  input  regbits_t         dec_rt,
  input  logic             ex_br_taken,
  input  logic             dec_jump,
  input  logic             flush_done,
  output logic             pc_en,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_req,
  output logic             halt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  pipe_state_t state, next_state;
  latch_ctl_t  ctl, run_c;
  logic        dreq, lu;

  assign dreq  = mem_memRen | mem_memWen;
  assign lu    = ex_memRen && (ex_regDest != '0) &&
                 ((ex_regDest == dec_rs) || (ex_regDest == dec_rt));
  assign run_c = run_ctl(ihit, ex_br_taken, lu, dec_jump);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      flush_req <= 1'b0;
      halt      <= 1'b0;
    end else begin
      state     <= next_state;
      flush_req <= (next_state == HALTING);
      halt      <= (next_state == HALTED);
    end
  end

  always_comb begin
    next_state = state;
    ctl        = CTL_IDLE;
    unique case (state)
      RUN: begin
        if (dreq && !dhit) begin
          next_state = DWAIT;
        end else if (mem_halt) begin
          next_state    = HALTING;
          ctl.en_mem_wb = 1'b1;
        end else begin
          ctl = run_c;
        end
      end
      DWAIT: begin
        if (dhit) begin
          next_state = RUN;
          ctl        = run_c;
        end
      end
      HALTING: begin
        if (flush_done)
          next_state = HALTED;
      end
      HALTED: ;
    endcase
    if (!nRST)
      ctl = CTL_IDLE;
  end

  assign pc_en       = ctl.pc_en;
  assign en_if_id    = ctl.en_if_id;
  assign en_id_ex    = ctl.en_id_ex;
  assign en_ex_mem   = ctl.en_ex_mem;
  assign en_mem_wb   = ctl.en_mem_wb;
  assign flush_if_id = ctl.flush_if_id;
  assign flush_id_ex = ctl.flush_id_ex;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (state != HALTED),
    .count (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (((state == RUN) || (state == DWAIT)) && !ctl.pc_en),
    .count (stall_cnt)
  );
endmodule
